ec_l4_pool_packer: RTL and testbench

EC_L4_POOL_PACKER -- requirements
Module: ec_l4_pool_packer

---
 rtl/ec_l4_pool_packer.sv | 103 ++++++++++
 tb/tb_ec_l4_pool_packer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ec_l4_pool_packer.sv
// ec_l4_pool_packer: packs per-channel PE_EC_L4 pool results into one word per pooled pixel
//   clk, rst (async, active-high), clr (sync frame abort)
//   in_valid/in_ready/in_data_4 : one channel per accept, one-hot pool index or zero
//   out_valid/out_ready/out_act/out_mask/out_eol/out_eof : packed pixel word from a 2-entry FIFO
//   err : sticky flag, set when an accepted nibble has more than one bit set
module ec_l4_pool_packer #(
   parameter int N_CH  = 64,
   parameter int OUT_W = 14,
   parameter int OUT_H = 14
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          in_data_4,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [N_CH-1:0]     out_act,
   output logic [4*N_CH-1:0]   out_mask,
   output logic                out_eol,
   output logic                out_eof,
   output logic                err
);
   localparam int CHW = $clog2(N_CH);
   localparam int CW  = OUT_W > 1 ? $clog2(OUT_W) : 1;
   localparam int RW  = OUT_H > 1 ? $clog2(OUT_H) : 1;
   localparam int WW  = 5 * N_CH + 2;
   logic [CHW-1:0]    ch;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [N_CH-1:0]   act_acc, act_nxt;
   logic [4*N_CH-1:0] mask_acc, mask_nxt;
   logic [WW-1:0]     fifo [2];
   logic [1:0]        cnt;
   logic              accept, push, pop, eol, eof, wr;
   assign accept    = in_valid && in_ready;
   assign push      = accept && (ch == CHW'(N_CH - 1));
   assign out_valid = cnt != 2'd0;
   assign pop       = out_valid && out_ready;
   assign in_ready  = !rst && !clr && (cnt < 2'd2);
   assign eol       = col == CW'(OUT_W - 1);
   assign eof       = eol && (row == RW'(OUT_H - 1));
   // push lands behind whatever survives this cycle's pop
   assign wr        = cnt[0] && !pop;
   assign out_act   = out_valid ? fifo[0][WW-1 -: N_CH] : '0;
   assign out_mask  = out_valid ? fifo[0][4*N_CH+1 -: 4*N_CH] : '0;
   assign out_eol   = out_valid && fifo[0][1];
   assign out_eof   = out_valid && fifo[0][0];
   always_comb begin
      act_nxt               = act_acc;
      mask_nxt              = mask_acc;
      act_nxt[ch]           = |in_data_4;
      mask_nxt[4*ch +: 4]   = in_data_4;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch       <= '0;
         col      <= '0;
         row      <= '0;
         cnt      <= '0;
         err      <= 1'b0;
         act_acc  <= '0;
         mask_acc <= '0;
         fifo[0]  <= '0;
         fifo[1]  <= '0;
      end else if (clr) begin
         ch       <= '0;
         col      <= '0;
         row      <= '0;
         cnt      <= '0;
         err      <= 1'b0;
         act_acc  <= '0;
         mask_acc <= '0;
         fifo[0]  <= '0;
         fifo[1]  <= '0;
      end else begin
         if (accept) begin
            act_acc  <= act_nxt;
            mask_acc <= mask_nxt;
            ch       <= ch + 1'b1;
            if ((in_data_4 & (in_data_4 - 4'd1)) != 4'd0)
               err <= 1'b1;
         end
         if (push) begin
            if (eof) begin
               col <= '0;
               row <= '0;
            end else if (eol) begin
               col <= '0;
               row <= row + 1'b1;
            end else
               col <= col + 1'b1;
         end
         if (pop)
            fifo[0] <= fifo[1];
         // a push with cnt==1 and a pop overrides the shift above
         if (push)
            fifo[wr] <= {act_nxt, mask_nxt, eol, eof};
         cnt <= cnt + {1'b0, push} - {1'b0, pop};
      end
   end
endmodule

// File: tb/tb_ec_l4_pool_packer.sv
// tb_ec_l4_pool_packer: directed scoreboard bench for ec_l4_pool_packer (N_CH=4, 2x2 frame)
module tb_ec_l4_pool_packer;
   logic        clk = 1'b0, rst = 1'b1, clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0]  in_data_4 = 4'd0;
   logic        in_ready, out_valid, out_eol, out_eof, err;
   logic [3:0]  out_act;
   logic [15:0] out_mask;
   logic [21:0] q [$];
   logic [15:0] pix;
   int          checks = 0, errors = 0, mcol = 0, mrow = 0;

   ec_l4_pool_packer #(.N_CH(4), .OUT_W(2), .OUT_H(2)) dut (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_data_4(in_data_4), .out_valid(out_valid), .out_ready(out_ready),
      .out_act(out_act), .out_mask(out_mask), .out_eol(out_eol), .out_eof(out_eof), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_push(input logic [15:0] p);
      logic [3:0] a;
      logic       e, f;
      for (int c = 0; c < 4; c++) a[c] = |p[4*c +: 4];
      e = (mcol == 1);
      f = e && (mrow == 1);
      q.push_back({a, p, e, f});
      if (f) begin
         mcol = 0;
         mrow = 0;
      end else if (e) begin
         mcol = 0;
         mrow++;
      end else
         mcol++;
   endtask

   task automatic model_reset();
      q.delete();
      mcol = 0;
      mrow = 0;
   endtask

   task automatic send(input logic [3:0] d);
      int n = 0;
      @(negedge clk);
      in_valid  = 1'b1;
      in_data_4 = d;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic send_pix(input logic [15:0] p);
      model_push(p);
      for (int c = 0; c < 4; c++) send(p[4*c +: 4]);
   endtask

   function automatic logic [15:0] rnd_pix();
      logic [15:0] p;
      int          r;
      for (int c = 0; c < 4; c++) begin
         r = $urandom_range(0, 4);
         p[4*c +: 4] = (r == 4) ? 4'd0 : (4'd1 << r);
      end
      return p;
   endfunction

   task automatic wait_empty();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         assert (q.size() != 0) else begin
            errors++;
            $error("FAIL extra_word got=%h exp=none", {out_act, out_mask, out_eol, out_eof});
         end
         if (q.size() != 0) chk("word", 32'({out_act, out_mask, out_eol, out_eof}), 32'(q.pop_front()));
      end
   end

   initial begin
      #2;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_outs", 32'({out_act, out_mask, out_eol, out_eof, err}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(in_ready), 32'd1);

      // basic packing, latency 1
      out_ready = 1'b1;
      send_pix(16'h8401);
      @(negedge clk);
      chk("r31_valid", 32'(out_valid), 32'd1);
      chk("r31_act", 32'(out_act), 32'hd);
      chk("r31_mask", 32'(out_mask), 32'h8401);
      chk("r31_tags", 32'({out_eol, out_eof, err}), 32'd0);

      // frame tags: words 2..5 of the 2x2 frame
      send_pix(rnd_pix());
      @(negedge clk);
      chk("w2_tags", 32'({out_eol, out_eof}), 32'b10);
      send_pix(rnd_pix());
      send_pix(rnd_pix());
      @(negedge clk);
      chk("w4_tags", 32'({out_eol, out_eof}), 32'b11);
      send_pix(rnd_pix());
      @(negedge clk);
      chk("w5_tags", 32'({out_eol, out_eof}), 32'b00);
      wait_empty();

      // backpressure: two words buffered, third blocked
      @(posedge clk);
      #1 out_ready = 1'b0;
      send_pix(rnd_pix());
      send_pix(rnd_pix());
      @(negedge clk);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      in_valid  = 1'b1;
      in_data_4 = 4'b0010;
      repeat (3) begin
         @(negedge clk);
         chk("blocked", 32'(in_ready), 32'd0);
         chk("hold_word", 32'({out_valid, out_act, out_mask}), 32'({1'b1, q[0][21:2]}));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      chk("pop_cycle_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("after_pop_ready", 32'(in_ready), 32'd1);
      pix = rnd_pix();
      pix[3:0] = 4'b0010;
      send_pix(pix);
      wait_empty();

      // illegal input sets sticky err
      send_pix(16'h1308);
      @(negedge clk);
      chk("err_set", 32'(err), 32'd1);
      send_pix(rnd_pix());
      @(negedge clk);
      chk("err_sticky", 32'(err), 32'd1);
      wait_empty();
      clr = 1'b1;
      #1 chk("clr_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      clr = 1'b0;
      model_reset();
      #1 chk("err_clr", 32'(err), 32'd0);

      // clr mid-word discards partial data and restarts at (0,0)
      send(4'b0001);
      send(4'b0010);
      @(negedge clk);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      model_reset();
      send_pix(16'h8000);
      @(negedge clk);
      chk("clr_word", 32'({out_act, out_mask, out_eol, out_eof}), 32'({4'b1000, 16'h8000, 2'b00}));
      send_pix(rnd_pix());
      wait_empty();

      // async reset with one buffered word and a partial word
      @(posedge clk);
      #1 out_ready = 1'b0;
      send_pix(rnd_pix());
      send(4'b0100);
      @(negedge clk);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_valid", 32'(out_valid), 32'd0);
      chk("async_ready", 32'(in_ready), 32'd0);
      chk("async_outs", 32'({out_act, out_mask, out_eol, out_eof, err}), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 out_ready = 1'b1;
      send_pix(16'h0012);
      @(negedge clk);
      chk("post_rst_word", 32'({out_act, out_mask, out_eol, out_eof}), 32'({4'b0011, 16'h0012, 2'b00}));
      send_pix(rnd_pix());
      wait_empty();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
